ext_mem_burst_master: RTL and testbench
=======================================

// Module: ext_mem_burst_master
// PURPOSE
//  Initiator for the external data memory port (cslt/wrb/add/data, 2-cycle registered read).
//  Accepts one burst command (read or write, start address, length) from the core.
//  Streams write words out, or issues pipelined reads and returns a read stream.
//  Sits between the core/DMA logic and memory_ext_1; owns every memory-side strobe.
// PARAMETERS
//  DMA_SIZE  3  memory address width; burst address wraps modulo 2**DMA_SIZE
//  DMD_SIZE  4  memory data width
// PORTS
//  clk        in   1         single clock; all logic on posedge
//  rst_n      in   1         asynchronous, active-low reset
//  req_valid  in   1         burst command valid
//  req_ready  out  1         command accepted when req_valid&req_ready; =1 only in IDLE
//  req_wr     in   1         1=write burst, 0=read burst
//  req_add    in   DMA_SIZE  start address
//  req_len    in   DMA_SIZE  burst length minus 1 (0 -> 1 word, all-ones -> 2**DMA_SIZE words)
//  wr_valid   in   1         write word available
//  wr_ready   out  1         =1 in WR state; word taken on wr_valid&wr_ready
//  wr_data    in   DMD_SIZE  write word
//  rd_valid   out  1         read word valid, one-cycle pulse per word, no backpressure
//  rd_data    out  DMD_SIZE  read word
//  rd_last    out  1         with rd_valid on final word of the burst
//  done       out  1         one-cycle pulse, burst fully retired
//  ps_dm_cslt out  1         memory chip select (registered)
//  ps_dm_wrb  out  1         memory 1=write 0=read (registered)
//  dg_dm_add  out  DMA_SIZE  memory address (registered)
//  bc_dt      out  DMD_SIZE  memory write data (registered)
//  dm_bc_dt   in   DMD_SIZE  memory read data
// BEHAVIOUR
//  - Reset: state IDLE; all registered outputs 0 (cslt, wrb, add, bc_dt, rd_*, done); counters 0.
//    Asynchronous: an in-flight burst is abandoned, cslt drops immediately, and already-written words stay in memory.
//  - FSM: IDLE -> WR (accepted, req_wr=1) | RD (accepted, req_wr=0); WR/RD -> DRAIN after last beat issued;
//    DRAIN -> IDLE when the issue register is idle and the read pipe is empty; done=1 in the cycle after the DRAIN exit edge.
//  - Command latch: add_cnt<=req_add, beat_cnt<=req_len; req_* ignored outside IDLE.
//  - WR: on wr handshake, next cycle cslt=1, wrb=1, add=add_cnt, bc_dt=wr_data; add_cnt+1 (wraps), beat_cnt-1.
//    wr_valid=0 -> cslt=0 that cycle (bubble), counters hold. Last beat = handshake with beat_cnt==0.
//  - RD: one read issued per cycle: cslt=1, wrb=0, add=add_cnt; no bubbles; 2**DMA_SIZE words issue in 2**DMA_SIZE cycles.
//  - Read latency: issue cycle N (cslt out) -> memory latches at end of N -> dm_bc_dt valid in N+2 -> captured ->
//    rd_valid/rd_data in N+3. Valid tracked by a 3-deep shift register with tag (valid,last); dm_bc_dt is never used untagged.
//  - rd_last tags the word issued with beat_cnt==0.
//  - Idle cycles: cslt=0, wrb=0; add and bc_dt hold their last values.
//  - Write then read of the same address in back-to-back bursts returns the new data; the memory write precedes the read by at least 2 cycles.
//  - done and req_ready are high in the same cycle, so a new command may be accepted on that cycle.
//  - Address arithmetic is unsigned DMA_SIZE bits; carry out is discarded, so 7+1 -> 0 at DMA_SIZE=3.
// STRUCTURE
//  - ext_mem_pkg: state encoding (IDLE/WR/RD/DRAIN) and read-latency constant RD_LAT=3.
//  - Sub-module ext_mem_rd_pipe: tag shift register plus data capture; outputs rd_valid/rd_data/rd_last and a pipe-empty flag.
//  - Top: FSM, address/beat counters, memory-side output registers.
// TESTING (bench instantiates memory_ext_1 as the slave)
//  - Write burst add=6, len=3, data A,B,C,D, wr_valid steady -> mem[6]=A,[7]=B,[0]=C,[1]=D; 4 consecutive cslt; done once.
//  - Read burst add=6, len=3 -> rd_valid in 4 consecutive cycles, first word 3 cycles after first cslt; data A,B,C,D; rd_last only on D.
//  - Write len=2 with wr_valid low for 2 cycles mid-burst -> cslt shows 2 bubbles; 3 words written; no extra cslt.
//  - Full burst add=0, len=7 -> 8 reads, add stays in 0..7, done 1 cycle after DRAIN exit; next req accepted in the done cycle.
//  - rst_n low during a read burst at beat 2 -> cslt/rd_valid go 0 at once; no done; next burst behaves normally.
//  - req_valid held during RD -> req_ready=0, command ignored until IDLE, then accepted exactly once.

Source files
------------

// File: rtl/ext_mem_pkg.sv
// Shared types for the external data-memory burst master: FSM encoding,
// read-pipe tag layout and the memory read latency seen at the master.
package ext_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Cycles from a read's chip-select cycle to rd_valid at the core side.
    localparam int RD_LAT = 3;

    typedef struct packed {
        logic valid;
        logic last;
    } rd_tag_t;

endpackage

// File: rtl/ext_mem_rd_pipe.sv
// Read return pipe: tags each issued read and captures memory data only when
// a tagged word reaches the end of the pipe.
module ext_mem_rd_pipe
    import ext_mem_pkg::*;
#(
    parameter int DMD_SIZE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue,
    input  logic                issue_last,
    input  logic [DMD_SIZE-1:0] mem_data,
    output logic                rd_valid,
    output logic [DMD_SIZE-1:0] rd_data,
    output logic                rd_last,
    output logic                empty
);

    // tag[0] lines up with the cycle chip select is driven for that read.
    rd_tag_t tag [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag[i] <= '0;
            end
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
        end else begin
            tag[0] <= {issue, issue & issue_last};
            for (int i = 1; i < RD_LAT; i++) begin
                tag[i] <= tag[i-1];
            end
            rd_valid <= tag[RD_LAT-1].valid;
            rd_last  <= tag[RD_LAT-1].valid & tag[RD_LAT-1].last;
            if (tag[RD_LAT-1].valid) begin
                rd_data <= mem_data;
            end
        end
    end

    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < RD_LAT; i++) begin
            if (tag[i].valid) begin
                empty = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ext_mem_burst_master.sv
// Burst initiator for the external data memory port: accepts one read or
// write burst command and owns every memory-side strobe.
module ext_mem_burst_master
    import ext_mem_pkg::*;
#(
    parameter int DMA_SIZE = 3,
    parameter int DMD_SIZE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wr,
    input  logic [DMA_SIZE-1:0] req_add,
    input  logic [DMA_SIZE-1:0] req_len,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [DMD_SIZE-1:0] wr_data,
    output logic                rd_valid,
    output logic [DMD_SIZE-1:0] rd_data,
    output logic                rd_last,
    output logic                done,
    output logic                ps_dm_cslt,
    output logic                ps_dm_wrb,
    output logic [DMA_SIZE-1:0] dg_dm_add,
    output logic [DMD_SIZE-1:0] bc_dt,
    input  logic [DMD_SIZE-1:0] dm_bc_dt
);

    // Handshakes: a command moves on req_valid&req_ready, a write word on
    // wr_valid&wr_ready, both sampled at posedge; rd_valid has no backpressure.
    state_t              state;
    state_t              state_nx;
    logic [DMA_SIZE-1:0] add_cnt;
    logic [DMA_SIZE-1:0] beat_cnt;
    logic                wr_beat;
    logic                rd_beat;
    logic                last_beat;
    logic                pipe_empty;

    assign req_ready = (state == IDLE);
    assign wr_ready  = (state == WR);

    always_comb begin
        state_nx  = state;
        wr_beat   = 1'b0;
        rd_beat   = 1'b0;
        last_beat = (beat_cnt == '0);
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nx = req_wr ? WR : RD;
                end
            end
            WR: begin
                wr_beat = wr_valid;
                if (wr_valid && last_beat) begin
                    state_nx = DRAIN;
                end
            end
            RD: begin
                rd_beat = 1'b1;
                if (last_beat) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                // Retired once the final strobe has gone out and no read is in flight.
                if (!ps_dm_cslt && pipe_empty) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            add_cnt    <= '0;
            beat_cnt   <= '0;
            ps_dm_cslt <= 1'b0;
            ps_dm_wrb  <= 1'b0;
            dg_dm_add  <= '0;
            bc_dt      <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            done       <= (state == DRAIN) && (state_nx == IDLE);
            ps_dm_cslt <= wr_beat | rd_beat;
            ps_dm_wrb  <= wr_beat;
            if (state == IDLE && req_valid) begin
                add_cnt  <= req_add;
                beat_cnt <= req_len;
            end
            if (wr_beat || rd_beat) begin
                dg_dm_add <= add_cnt;
                add_cnt   <= add_cnt + 1'b1;
                beat_cnt  <= beat_cnt - 1'b1;
            end
            if (wr_beat) begin
                bc_dt <= wr_data;
            end
        end
    end

    ext_mem_rd_pipe #(
        .DMD_SIZE(DMD_SIZE)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (rd_beat),
        .issue_last(last_beat),
        .mem_data  (dm_bc_dt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .empty     (pipe_empty)
    );

endmodule

// File: tb/tb_ext_mem_burst_master.sv
// Bench for ext_mem_burst_master with a behavioural 2-cycle registered-read
// memory slave; expected words and write beats are queued as stimulus is set up.
module tb_ext_mem_burst_master;

    localparam int DMA_SIZE = 3;
    localparam int DMD_SIZE = 4;
    localparam int DEPTH    = 1 << DMA_SIZE;
    localparam int RW       = DMD_SIZE + 1;
    localparam int WW       = DMA_SIZE + DMD_SIZE;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                req_valid;
    logic                req_ready;
    logic                req_wr;
    logic [DMA_SIZE-1:0] req_add;
    logic [DMA_SIZE-1:0] req_len;
    logic                wr_valid;
    logic                wr_ready;
    logic [DMD_SIZE-1:0] wr_data;
    logic                rd_valid;
    logic [DMD_SIZE-1:0] rd_data;
    logic                rd_last;
    logic                done;
    logic                ps_dm_cslt;
    logic                ps_dm_wrb;
    logic [DMA_SIZE-1:0] dg_dm_add;
    logic [DMD_SIZE-1:0] bc_dt;
    logic [DMD_SIZE-1:0] dm_bc_dt;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // ---------------- clock / DUT / memory slave ----------------
    always #5 clk = ~clk;

    ext_mem_burst_master #(
        .DMA_SIZE(DMA_SIZE),
        .DMD_SIZE(DMD_SIZE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_add   (req_add),
        .req_len   (req_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .done      (done),
        .ps_dm_cslt(ps_dm_cslt),
        .ps_dm_wrb (ps_dm_wrb),
        .dg_dm_add (dg_dm_add),
        .bc_dt     (bc_dt),
        .dm_bc_dt  (dm_bc_dt)
    );

    // Memory latches the strobe at the end of the cslt cycle; data shows up two cycles later.
    logic [DMD_SIZE-1:0] mem [DEPTH];
    logic [DMD_SIZE-1:0] mem_q;
    always @(posedge clk) begin
        if (ps_dm_cslt && ps_dm_wrb) mem[dg_dm_add] <= bc_dt;
        if (ps_dm_cslt && !ps_dm_wrb) mem_q <= mem[dg_dm_add];
        dm_bc_dt <= mem_q;
    end

    // ---------------- scoreboard state ----------------
    logic [DMD_SIZE-1:0] model [DEPTH];
    logic [RW-1:0]       exp_q[$];
    logic [WW-1:0]       wexp_q[$];
    logic [DMD_SIZE-1:0] wr_src_q[$];
    logic [RW-1:0]       obs_q[$];
    logic [DMA_SIZE-1:0] aq[$];
    logic [DMD_SIZE-1:0] dq[$];
    int first_cslt, last_cslt, first_rd, last_rd, done_cyc, n_cslt, n_done, ready_at_done;

    // ---------------- driver tasks ----------------
    task automatic queue_write(input logic [DMA_SIZE-1:0] a, input logic [DMD_SIZE-1:0] d);
        wr_src_q.push_back(d);
        wexp_q.push_back({a, d});
        model[a] = d;
    endtask

    task automatic queue_read(input logic [DMA_SIZE-1:0] a, input logic last);
        exp_q.push_back({last, model[a]});
    endtask

    task automatic send_cmd(input logic wr, input logic [DMA_SIZE-1:0] a, input logic [DMA_SIZE-1:0] l);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_add   = a;
        req_len   = l;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk_cnt++;
            $display("FAIL cmd_accept: req_ready=0 after %0d cycles, required 1", n);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Runs one burst from the cycle after acceptance until done, feeding write words.
    task automatic watch(input int budget, input int gap_at, input int gap_len);
        int handed;
        int gap_rem;
        int cyc;
        handed = 0; gap_rem = gap_len; cyc = 0;
        first_cslt = -1; last_cslt = -1; first_rd = -1; last_rd = -1;
        done_cyc = -1; n_cslt = 0; n_done = 0; ready_at_done = 0;
        obs_q.delete(); aq.delete(); dq.delete();
        while (cyc < budget && n_done == 0) begin
            if (ps_dm_cslt) begin
                n_cslt++;
                if (first_cslt < 0) first_cslt = cyc;
                last_cslt = cyc;
                aq.push_back(dg_dm_add);
                if (ps_dm_wrb) dq.push_back(bc_dt);
            end
            if (rd_valid) begin
                obs_q.push_back({rd_last, rd_data});
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                ready_at_done = int'(req_ready);
            end
            wr_valid = 1'b0;
            if (wr_src_q.size() > 0) begin
                if (handed == gap_at && gap_rem > 0) begin
                    gap_rem--;
                end else begin
                    wr_valid = 1'b1;
                    wr_data  = wr_src_q[0];
                    if (wr_ready) begin
                        void'(wr_src_q.pop_front());
                        handed++;
                    end
                end
            end
            if (n_done == 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        wr_valid = 1'b0;
        if (n_done == 0) begin
            chk_cnt++;
            $display("FAIL burst_timeout: no done within %0d cycles, required done", budget);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if ({ps_dm_cslt, ps_dm_wrb, dg_dm_add, bc_dt, rd_valid, rd_data, rd_last, done} !== '0)
            $display("FAIL reset_outputs: got %b, required all 0",
                     {ps_dm_cslt, ps_dm_wrb, dg_dm_add, bc_dt, rd_valid, rd_data, rd_last, done});
        else pass_cnt++;
        chk_cnt++;
        if (req_ready !== 1'b1 || wr_ready !== 1'b0)
            $display("FAIL reset_ready: req_ready=%b wr_ready=%b, required 1 0", req_ready, wr_ready);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_burst();
        logic [WW-1:0] got_w;
        logic [WW-1:0] want_w;
        int idle_cslt;
        int idle_done;
        queue_write(3'd6, 4'hA);
        queue_write(3'd7, 4'hB);
        queue_write(3'd0, 4'hC);
        queue_write(3'd1, 4'hD);
        send_cmd(1'b1, 3'd6, 3'd3);
        watch(40, -1, 0);
        chk_cnt++;
        if (n_cslt != 4 || last_cslt - first_cslt != 3)
            $display("FAIL wr_cslt_run: got %0d cslt over %0d cycles, required 4 over 4", n_cslt, last_cslt - first_cslt + 1);
        else pass_cnt++;
        chk_cnt++;
        if (dq.size() != 4) $display("FAIL wr_beats: got %0d, required 4", dq.size());
        else pass_cnt++;
        for (int i = 0; i < aq.size() && i < dq.size(); i++) begin
            got_w = {aq[i], dq[i]};
            chk_cnt++;
            if (wexp_q.size() == 0) begin
                $display("FAIL wr_seq: extra beat %h, required none", got_w);
            end else begin
                want_w = wexp_q.pop_front();
                if (got_w !== want_w) $display("FAIL wr_seq: got %h, required %h", got_w, want_w);
                else pass_cnt++;
            end
        end
        wexp_q.delete();
        chk_cnt++;
        if (done_cyc != last_cslt + 2) $display("FAIL wr_done_time: got %0d, required %0d", done_cyc, last_cslt + 2);
        else pass_cnt++;
        chk_cnt++;
        if ({mem[6], mem[7], mem[0], mem[1]} !== 16'hABCD)
            $display("FAIL wr_mem_wrap: got %h%h%h%h, required abcd", mem[6], mem[7], mem[0], mem[1]);
        else pass_cnt++;
        idle_cslt = 0; idle_done = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ps_dm_cslt) idle_cslt++;
            if (done) idle_done++;
        end
        chk_cnt++;
        if (idle_cslt != 0 || idle_done != 0)
            $display("FAIL wr_after_done: cslt=%0d done=%0d, required 0 0", idle_cslt, idle_done);
        else pass_cnt++;
    endtask

    task automatic test_read_burst();
        logic [RW-1:0] got_r;
        logic [RW-1:0] want_r;
        queue_read(3'd6, 1'b0);
        queue_read(3'd7, 1'b0);
        queue_read(3'd0, 1'b0);
        queue_read(3'd1, 1'b1);
        send_cmd(1'b0, 3'd6, 3'd3);
        watch(40, -1, 0);
        chk_cnt++;
        if (obs_q.size() != 4 || last_rd - first_rd != 3)
            $display("FAIL rd_run: got %0d words over %0d cycles, required 4 over 4", obs_q.size(), last_rd - first_rd + 1);
        else pass_cnt++;
        chk_cnt++;
        if (first_rd - first_cslt != 3) $display("FAIL rd_latency: got %0d, required 3", first_rd - first_cslt);
        else pass_cnt++;
        while (obs_q.size() > 0) begin
            got_r = obs_q.pop_front();
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL rd_word: extra word %h, required none", got_r);
            end else begin
                want_r = exp_q.pop_front();
                if (got_r !== want_r) $display("FAIL rd_word: got {last,data}=%h, required %h", got_r, want_r);
                else pass_cnt++;
            end
        end
        exp_q.delete();
        chk_cnt++;
        if (n_done != 1 || done_cyc != last_rd + 1)
            $display("FAIL rd_done_time: got cycle %0d, required %0d", done_cyc, last_rd + 1);
        else pass_cnt++;
    endtask

    task automatic test_write_bubble();
        logic [WW-1:0] got_w;
        logic [WW-1:0] want_w;
        int idle_cslt;
        queue_write(3'd2, 4'h1);
        queue_write(3'd3, 4'h2);
        queue_write(3'd4, 4'h3);
        send_cmd(1'b1, 3'd2, 3'd2);
        watch(40, 1, 2);
        chk_cnt++;
        if (n_cslt != 3 || (last_cslt - first_cslt + 1) - n_cslt != 2)
            $display("FAIL bubble_cslt: got %0d cslt span %0d, required 3 cslt with 2 bubbles", n_cslt, last_cslt - first_cslt + 1);
        else pass_cnt++;
        for (int i = 0; i < aq.size() && i < dq.size(); i++) begin
            got_w = {aq[i], dq[i]};
            chk_cnt++;
            if (wexp_q.size() == 0) begin
                $display("FAIL bubble_seq: extra beat %h, required none", got_w);
            end else begin
                want_w = wexp_q.pop_front();
                if (got_w !== want_w) $display("FAIL bubble_seq: got %h, required %h", got_w, want_w);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (wexp_q.size() != 0) $display("FAIL bubble_missing: %0d beats never seen, required 0", wexp_q.size());
        else pass_cnt++;
        wexp_q.delete();
        idle_cslt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ps_dm_cslt) idle_cslt++;
        end
        chk_cnt++;
        if (idle_cslt != 0 || {mem[2], mem[3], mem[4]} !== 12'h123)
            $display("FAIL bubble_mem: extra cslt=%0d mem=%h%h%h, required 0 and 123", idle_cslt, mem[2], mem[3], mem[4]);
        else pass_cnt++;
    endtask

    task automatic test_full_burst();
        logic [RW-1:0]       got_r;
        logic [RW-1:0]       want_r;
        logic [DMA_SIZE-1:0] ea;
        for (int a = 0; a < DEPTH; a++) queue_write(DMA_SIZE'(a), DMD_SIZE'($urandom_range(0, 15)));
        send_cmd(1'b1, 3'd0, 3'd7);
        watch(60, -1, 0);
        chk_cnt++;
        if (n_cslt != 8 || ready_at_done != 1)
            $display("FAIL full_wr: cslt=%0d ready_at_done=%0d, required 8 1", n_cslt, ready_at_done);
        else pass_cnt++;
        wexp_q.delete();
        // Read accepted in the write's done cycle: same addresses, fresh data.
        for (int a = 0; a < DEPTH; a++) queue_read(DMA_SIZE'(a), a == DEPTH - 1);
        send_cmd(1'b0, 3'd0, 3'd7);
        watch(60, -1, 0);
        chk_cnt++;
        if (n_cslt != 8 || last_cslt - first_cslt != 7)
            $display("FAIL full_rd_issue: got %0d cslt over %0d cycles, required 8 over 8", n_cslt, last_cslt - first_cslt + 1);
        else pass_cnt++;
        for (int i = 0; i < aq.size(); i++) begin
            ea = DMA_SIZE'(i);
            chk_cnt++;
            if (aq[i] !== ea) $display("FAIL full_rd_add: beat %0d got %0d, required %0d", i, aq[i], ea);
            else pass_cnt++;
        end
        chk_cnt++;
        if (obs_q.size() != 8) $display("FAIL full_rd_count: got %0d, required 8", obs_q.size());
        else pass_cnt++;
        while (obs_q.size() > 0) begin
            got_r = obs_q.pop_front();
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL full_rd_word: extra word %h, required none", got_r);
            end else begin
                want_r = exp_q.pop_front();
                if (got_r !== want_r) $display("FAIL full_rd_word: got %h, required %h", got_r, want_r);
                else pass_cnt++;
            end
        end
        exp_q.delete();
        chk_cnt++;
        if (done_cyc != last_rd + 1 || ready_at_done != 1)
            $display("FAIL full_rd_done: cycle %0d ready=%0d, required %0d 1", done_cyc, ready_at_done, last_rd + 1);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_read();
        logic [RW-1:0] got_r;
        logic [RW-1:0] want_r;
        int seen;
        int late_rd;
        int late_done;
        int late_cslt;
        seen = 0;
        send_cmd(1'b0, 3'd0, 3'd7);
        for (int c = 0; c < 20 && seen < 3; c++) begin
            if (ps_dm_cslt) seen++;
            if (seen < 3) @(negedge clk);
        end
        chk_cnt++;
        if (ps_dm_cslt !== 1'b1) $display("FAIL rst_pre: cslt=%b at beat 2, required 1", ps_dm_cslt);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (ps_dm_cslt !== 1'b0 || rd_valid !== 1'b0 || done !== 1'b0)
            $display("FAIL rst_async: cslt=%b rd_valid=%b done=%b, required 0 0 0", ps_dm_cslt, rd_valid, done);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        late_rd = 0; late_done = 0; late_cslt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rd_valid) late_rd++;
            if (done) late_done++;
            if (ps_dm_cslt) late_cslt++;
        end
        chk_cnt++;
        if (late_rd != 0 || late_done != 0 || late_cslt != 0)
            $display("FAIL rst_quiet: rd_valid=%0d done=%0d cslt=%0d, required 0 0 0", late_rd, late_done, late_cslt);
        else pass_cnt++;
        queue_read(3'd6, 1'b0);
        queue_read(3'd7, 1'b1);
        send_cmd(1'b0, 3'd6, 3'd1);
        watch(40, -1, 0);
        chk_cnt++;
        if (obs_q.size() != 2) $display("FAIL rst_next_count: got %0d, required 2", obs_q.size());
        else pass_cnt++;
        while (obs_q.size() > 0) begin
            got_r = obs_q.pop_front();
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL rst_next_word: extra word %h, required none", got_r);
            end else begin
                want_r = exp_q.pop_front();
                if (got_r !== want_r) $display("FAIL rst_next_word: got %h, required %h", got_r, want_r);
                else pass_cnt++;
            end
        end
        exp_q.delete();
    endtask

    task automatic test_hold();
        logic [RW-1:0] got_r;
        logic [RW-1:0] want_r;
        int busy;
        int acc;
        int done_at_acc;
        int nd;
        busy = 0; acc = -1; done_at_acc = 0; nd = 0;
        obs_q.delete();
        for (int a = 0; a < 4; a++) queue_read(DMA_SIZE'(a), a == 3);
        queue_read(3'd5, 1'b1);
        send_cmd(1'b0, 3'd0, 3'd3);
        req_valid = 1'b1; req_wr = 1'b0; req_add = 3'd5; req_len = 3'd0;
        for (int c = 0; c < 30; c++) begin
            if (rd_valid) obs_q.push_back({rd_last, rd_data});
            if (done) nd++;
            if (req_valid) begin
                if (req_ready) begin
                    acc = c;
                    done_at_acc = int'(done);
                end else begin
                    busy++;
                end
            end
            @(negedge clk);
            if (acc >= 0) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        chk_cnt++;
        if (busy != 8 || acc != 8 || done_at_acc != 1)
            $display("FAIL hold_accept: busy=%0d accept=%0d done_then=%0d, required 8 8 1", busy, acc, done_at_acc);
        else pass_cnt++;
        chk_cnt++;
        if (obs_q.size() != 5 || nd != 2)
            $display("FAIL hold_once: words=%0d done=%0d, required 5 2", obs_q.size(), nd);
        else pass_cnt++;
        while (obs_q.size() > 0) begin
            got_r = obs_q.pop_front();
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL hold_word: extra word %h, required none", got_r);
            end else begin
                want_r = exp_q.pop_front();
                if (got_r !== want_r) $display("FAIL hold_word: got %h, required %h", got_r, want_r);
                else pass_cnt++;
            end
        end
        exp_q.delete();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_add   = '0;
        req_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
        test_reset();
        test_write_burst();
        test_read_burst();
        test_write_bubble();
        test_full_burst();
        test_reset_mid_read();
        test_hold();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
